// File: rtl/frame_geometry.sv
// rtl/frame_geometry.sv - video frame geometry monitor with lock qualification
module frame_geometry #(
  parameter int DIM_W       = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             FrameIn,
  input  logic             LineIn,
  output logic [DIM_W-1:0] Width,
  output logic [DIM_W-1:0] Height,
  output logic             Locked,
  output logic             FrameDone,
  output logic             Overflow
);

  localparam logic [DIM_W-1:0] maxCount   = '1;
  localparam logic [DIM_W-1:0] oneCount   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       lockTarget = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    stSearch = 2'd0,
    stVerify = 2'd1,
    stLocked = 2'd2
  } lockState_t;

  // Edge-detect history; resets high so a stream already in flight is ignored.
  logic             frameQ;
  logic             lineQ;

  // Per-frame measurement state.
  logic             armed;
  logic             inLine;
  logic [DIM_W-1:0] lineCnt;
  logic [DIM_W-1:0] heightCnt;
  logic [DIM_W-1:0] refWidth;
  logic             haveRef;
  logic             mismatch;
  logic             satFrame;

  // Lock qualification state.
  lockState_t       state;
  logic [DIM_W-1:0] candWidth;
  logic [DIM_W-1:0] candHeight;
  logic [3:0]       stableCnt;

  logic             frameRise;
  logic             frameActive;
  logic             lineRise;
  logic             lineGrow;
  logic             lineClose;
  logic             frameEnd;
  logic             lineSat;
  logic             heightSat;
  logic             satNow;
  logic             closeMismatch;
  logic [DIM_W-1:0] endWidth;
  logic             endHasLine;
  logic             endGood;
  logic             candMatch;
  logic [3:0]       stableNext;

  // Decode strobes, line/frame events and the frame-end verdict.
  always_comb begin
    frameRise     = FrameIn & ~frameQ;
    // The rising edge itself already belongs to the frame so a line starting
    // on that edge is counted.
    frameActive   = FrameIn & (armed | frameRise);
    lineRise      = LineIn & ~lineQ & frameActive;
    lineGrow      = LineIn & inLine & frameActive & ~lineRise;
    // A close is still honoured on the frame-end edge (FrameIn already low).
    lineClose     = ~LineIn & lineQ & inLine & armed;
    frameEnd      = armed & ~FrameIn;
    lineSat       = lineGrow & (lineCnt == maxCount);
    heightSat     = lineRise & ~frameRise & (heightCnt == maxCount);
    satNow        = lineSat | heightSat;
    closeMismatch = lineClose & haveRef & (lineCnt != refWidth);
    // A line closing on the frame-end edge may be the first one of the frame.
    endWidth      = haveRef ? refWidth : lineCnt;
    endHasLine    = haveRef | lineClose;
    endGood       = endHasLine & ~mismatch & ~closeMismatch & ~LineIn & ~satFrame;
    candMatch     = (endWidth == candWidth) & (heightCnt == candHeight);
    stableNext    = stableCnt + 4'd1;
  end

  // Measure line length, line count and per-frame consistency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frameQ    <= 1'b1;
      lineQ     <= 1'b1;
      armed     <= 1'b0;
      inLine    <= 1'b0;
      lineCnt   <= '0;
      heightCnt <= '0;
      refWidth  <= '0;
      haveRef   <= 1'b0;
      mismatch  <= 1'b0;
      satFrame  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      frameQ <= FrameIn;
      lineQ  <= LineIn;

      if (frameRise) begin
        armed <= 1'b1;
      end else if (frameEnd) begin
        armed <= 1'b0;
      end

      if (lineRise) begin
        inLine <= 1'b1;
      end else if (lineClose || frameEnd || frameRise) begin
        inLine <= 1'b0;
      end

      if (lineRise) begin
        lineCnt <= oneCount;
      end else if (lineGrow && !lineSat) begin
        lineCnt <= lineCnt + oneCount;
      end

      if (frameRise) begin
        heightCnt <= lineRise ? oneCount : '0;
      end else if (lineRise && !heightSat) begin
        heightCnt <= heightCnt + oneCount;
      end

      if (frameRise) begin
        haveRef <= 1'b0;
      end else if (lineClose && !haveRef) begin
        haveRef  <= 1'b1;
        refWidth <= lineCnt;
      end

      if (frameRise) begin
        mismatch <= 1'b0;
      end else if (closeMismatch) begin
        mismatch <= 1'b1;
      end

      if (frameRise) begin
        satFrame <= 1'b0;
      end else if (satNow) begin
        satFrame <= 1'b1;
      end

      if (satNow) begin
        Overflow <= 1'b1;
      end
    end
  end

  // Lock FSM: qualify consecutive identical good frames and publish geometry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= stSearch;
      candWidth  <= '0;
      candHeight <= '0;
      stableCnt  <= '0;
      Width      <= '0;
      Height     <= '0;
      Locked     <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      FrameDone <= frameEnd;
      if (frameEnd) begin
        case (state)
          stSearch: begin
            if (endGood) begin
              candWidth  <= endWidth;
              candHeight <= heightCnt;
              stableCnt  <= 4'd1;
              if (LOCK_FRAMES == 1) begin
                state  <= stLocked;
                Width  <= endWidth;
                Height <= heightCnt;
                Locked <= 1'b1;
              end else begin
                state <= stVerify;
              end
            end
          end
          stVerify: begin
            if (!endGood) begin
              state <= stSearch;
            end else if (candMatch) begin
              stableCnt <= stableNext;
              if (stableNext == lockTarget) begin
                state  <= stLocked;
                Width  <= candWidth;
                Height <= candHeight;
                Locked <= 1'b1;
              end
            end else begin
              candWidth  <= endWidth;
              candHeight <= heightCnt;
              stableCnt  <= 4'd1;
            end
          end
          stLocked: begin
            if (!(endGood && candMatch)) begin
              state  <= stSearch;
              Locked <= 1'b0;
            end
          end
          default: begin
            state  <= stSearch;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/frame_geometry.md
# frame_geometry

Parametrised geometry monitor for the video stream entering the Hough pipeline. It generalises the separate Width and Height measurement blocks into one unit. The unit measures active line length and line count per frame from the FrameIn/LineIn strobes, checks that every line in a frame has the same length, and only publishes Width/Height after the geometry has been stable for a configurable number of consecutive frames. Edge and Circle consume Width, Height and Locked from this block.

## Interface
- DIM_W, 8: width of the Width/Height outputs and of all internal counters.
- LOCK_FRAMES, 2: number of consecutive identical good frames required to assert Locked; legal range 1..15.
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- FrameIn  input  1  high for the duration of a frame.
- LineIn  input  1  high on each cycle carrying an active pixel of a line.
- Width  output  DIM_W  last locked line length, in pixels.
- Height  output  DIM_W  last locked line count.
- Locked  output  1  Width/Height describe the current stream.
- FrameDone  output  1  one-cycle pulse at the end of each measured frame.
- Overflow  output  1  sticky; a counter saturated since reset.

## Operation
- Registered copies of FrameIn and LineIn are held for edge detection. Both reset to 1, so a frame or line already in progress when Reset is released is ignored until its next rising edge.
- A frame is measured only if the FrameIn rising edge was seen (armed flag).
- LineIn is ignored whenever FrameIn is sampled low, and also while the block is not armed.
- Line counter: increments on each edge that samples LineIn=1 and FrameIn=1. It clears on each LineIn rising edge.
- Line completion: an edge that samples LineIn=0 with the previous LineIn=1 closes the line. The first closed line's length becomes the frame reference width. Any later closed line of different length sets the frame's mismatch flag.
- Height counter: increments on each LineIn rising edge inside an armed frame. It clears on each FrameIn rising edge.
- Frame end: the first edge sampling FrameIn=0 after FrameIn=1.
  - If LineIn and FrameIn fall on the same edge, the line closes normally.
  - If LineIn is still sampled high at frame end, the open line makes the frame bad.
- Good frame: at least one line, no mismatch, no open line, no saturation.
- Counters saturate at 2^DIM_W-1. Saturation sets Overflow (sticky until Reset) and makes the frame bad.
- Lock FSM, evaluated at frame end. A candidate (width, height) pair and a stable counter are held.
  - SEARCH:
    - Good frame: load candidate, set count to 1. Go to LOCKED if LOCK_FRAMES=1, else go to VERIFY.
    - Bad frame: stay in SEARCH.
  - VERIFY:
    - Good frame matching the candidate: increment count. When count reaches LOCK_FRAMES, go to LOCKED.
    - Good frame not matching: reload candidate, set count to 1, stay in VERIFY.
    - Bad frame: go to SEARCH.
  - LOCKED:
    - Matching good frame: stay in LOCKED.
    - Any other frame: go to SEARCH.
- Width/Height load the candidate on entry to LOCKED. They hold their value in all other states and are never cleared except by Reset.
- Locked=1 exactly while the FSM is in LOCKED.

## Timing
- Reset values: Width=0, Height=0, Locked=0, FrameDone=0, Overflow=0. The FSM resets to SEARCH and all counters reset to 0.
- Reset is asynchronous. Asserting it mid-frame discards the frame; no FrameDone is produced for that frame.
- FrameDone, Width, Height and Locked are registered. They change on the same edge that first samples FrameIn=0 after a frame, so latency is 1 cycle from the FrameIn fall.
- FrameDone pulses for every armed frame, good or bad.
- The minimum gap between frames is 1 cycle with FrameIn low. Back-to-back frames must be measured without loss.
- The minimum line gap is 1 cycle with LineIn low.

## Test plan
- LOCK_FRAMES=2, three frames of 4 lines x 10 pixels, 1-cycle line gaps:
  - FrameDone pulses after each frame.
  - After frame 1: Locked=0.
  - After frame 2: Locked=1, Width=10, Height=4.
  - After frame 3: Locked stays 1.
- While locked, send a frame where line 3 is 9 pixels:
  - Locked drops to 0 on that frame end; Width=10 and Height=4 are held.
  - Two further 10x4 frames re-assert Locked.
- FrameIn falls on the same edge as LineIn for a 10x4 frame: the frame counts as good. FrameIn falls one cycle before LineIn: the frame is bad and the FSM returns to SEARCH.
- DIM_W=4, a line of 20 pixels: Overflow=1, the frame is bad, Locked=0. Overflow stays 1 through subsequent good frames until Reset.
- Reset released while FrameIn and LineIn are high: no FrameDone for that partial frame. The next full frame is measured correctly.
- LOCK_FRAMES=1, a single 6x3 frame: Locked=1, Width=6, Height=3 on its frame end. LineIn pulses while FrameIn is low change nothing.
